// File: rtl/payload_demux.sv
// payload_demux: assembles RMII dibits into bytes and splits each packet into
// a pixel start address, a row of pixel bytes and a block of audio bytes.
// Anything after the audio block (FCS, padding) is dropped.
module payload_demux #(
  parameter int PIXELS_PER_PKT = 320,
  parameter int AUDIO_PER_PKT  = 16,
  parameter int FB_DEPTH       = 76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        addr_axiov,
  output logic [16:0] addr,
  output logic        pixel_axiov,
  output logic [7:0]  pixel,
  output logic        audio_axiov,
  output logic [7:0]  audio,
  output logic        pkt_done,
  output logic        pkt_err
);

  localparam logic [8:0]  PIX_LAST  = 9'(PIXELS_PER_PKT - 1);
  localparam logic [8:0]  AUD_LAST  = 9'((AUDIO_PER_PKT > 0) ? (AUDIO_PER_PKT - 1) : 0);
  localparam logic [16:0] ADDR_MAX  = 17'(FB_DEPTH - PIXELS_PER_PKT);
  localparam bit          HAS_AUDIO = (AUDIO_PER_PKT > 0);

  typedef enum logic [1:0] {HDR, PIXEL, AUDIO, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [1:0]  dibit_cnt;
  logic [5:0]  shreg;
  logic        in_pkt;
  logic [8:0]  byte_cnt, byte_cnt_nxt;
  logic        addr_ok, addr_ok_nxt;
  // hdr_hi holds header bit 16 (LSB of byte 0) and bits 15:8 (byte 1)
  logic [8:0]  hdr_hi, hdr_hi_nxt;

  logic        byte_done;
  logic        pkt_end;
  logic [7:0]  byte_val;
  logic [16:0] hdr_addr;

  logic        addr_axiov_nxt, pixel_axiov_nxt, audio_axiov_nxt;
  logic        pkt_done_nxt, pkt_err_nxt;
  logic [16:0] addr_nxt;
  logic [7:0]  pixel_nxt, audio_nxt;

  // A row must fit entirely inside the frame buffer
  function automatic logic addr_in_range(input logic [16:0] a);
    return (a <= ADDR_MAX);
  endfunction

  assign byte_done = axiiv && (dibit_cnt == 2'd3);
  assign pkt_end   = in_pkt && !axiiv;
  assign byte_val  = {shreg, axiid};
  assign hdr_addr  = {hdr_hi, byte_val};

  // Dibit shift register and phase counter; packet end drops any partial byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dibit_cnt <= 2'd0;
      shreg     <= 6'd0;
      in_pkt    <= 1'b0;
    end else begin
      in_pkt <= axiiv;
      if (pkt_end) begin
        dibit_cnt <= 2'd0;
      end else if (axiiv) begin
        shreg     <= {shreg[3:0], axiid};
        dibit_cnt <= dibit_cnt + 2'd1;
      end
    end
  end

  // Parser state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HDR;
      byte_cnt <= 9'd0;
      addr_ok  <= 1'b0;
      hdr_hi   <= 9'd0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      addr_ok  <= addr_ok_nxt;
      hdr_hi   <= hdr_hi_nxt;
    end
  end

  // Next-state and next-output decode, evaluated once per completed byte or packet end
  always_comb begin
    state_nxt       = state;
    byte_cnt_nxt    = byte_cnt;
    addr_ok_nxt     = addr_ok;
    hdr_hi_nxt      = hdr_hi;
    addr_axiov_nxt  = 1'b0;
    addr_nxt        = addr;
    pixel_axiov_nxt = 1'b0;
    pixel_nxt       = pixel;
    audio_axiov_nxt = 1'b0;
    audio_nxt       = audio;
    pkt_done_nxt    = 1'b0;
    pkt_err_nxt     = 1'b0;

    if (pkt_end) begin
      // Only a packet that reached the trailer counts as complete
      state_nxt    = HDR;
      byte_cnt_nxt = 9'd0;
      addr_ok_nxt  = 1'b0;
      if (state == DRAIN) pkt_done_nxt = 1'b1;
      else                pkt_err_nxt  = 1'b1;
    end else if (byte_done) begin
      case (state)
        HDR: begin
          if (byte_cnt == 9'd2) begin
            addr_nxt = hdr_addr;
            if (addr_in_range(hdr_addr)) begin
              addr_axiov_nxt = 1'b1;
              addr_ok_nxt    = 1'b1;
            end else begin
              addr_ok_nxt = 1'b0;
              pkt_err_nxt = 1'b1;
            end
            state_nxt    = PIXEL;
            byte_cnt_nxt = 9'd0;
          end else begin
            if (byte_cnt == 9'd0) hdr_hi_nxt[8]   = byte_val[0];
            else                  hdr_hi_nxt[7:0] = byte_val;
            byte_cnt_nxt = byte_cnt + 9'd1;
          end
        end
        PIXEL: begin
          // Bad-address rows are still consumed so the audio block lines up
          pixel_nxt       = byte_val;
          pixel_axiov_nxt = addr_ok;
          if (byte_cnt == PIX_LAST) begin
            state_nxt    = HAS_AUDIO ? AUDIO : DRAIN;
            byte_cnt_nxt = 9'd0;
          end else begin
            byte_cnt_nxt = byte_cnt + 9'd1;
          end
        end
        AUDIO: begin
          audio_nxt       = byte_val;
          audio_axiov_nxt = 1'b1;
          if (byte_cnt == AUD_LAST) begin
            state_nxt    = DRAIN;
            byte_cnt_nxt = 9'd0;
          end else begin
            byte_cnt_nxt = byte_cnt + 9'd1;
          end
        end
        DRAIN: begin
        end
        default: begin
          state_nxt    = HDR;
          byte_cnt_nxt = 9'd0;
        end
      endcase
    end
  end

  // Registered outputs; data holds between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_axiov  <= 1'b0;
      addr        <= 17'd0;
      pixel_axiov <= 1'b0;
      pixel       <= 8'd0;
      audio_axiov <= 1'b0;
      audio       <= 8'd0;
      pkt_done    <= 1'b0;
      pkt_err     <= 1'b0;
    end else begin
      addr_axiov  <= addr_axiov_nxt;
      addr        <= addr_nxt;
      pixel_axiov <= pixel_axiov_nxt;
      pixel       <= pixel_nxt;
      audio_axiov <= audio_axiov_nxt;
      audio       <= audio_nxt;
      pkt_done    <= pkt_done_nxt;
      pkt_err     <= pkt_err_nxt;
    end
  end

endmodule

// File: tb/tb_payload_demux.sv
// Directed bench for payload_demux: drives whole packets dibit by dibit and
// compares the logged strobes against hand-computed packet contents.
module tb_payload_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        addr_axiov;
  logic [16:0] addr;
  logic        pixel_axiov;
  logic [7:0]  pixel;
  logic        audio_axiov;
  logic [7:0]  audio;
  logic        pkt_done;
  logic        pkt_err;

  payload_demux #(
    .PIXELS_PER_PKT(320),
    .AUDIO_PER_PKT (16),
    .FB_DEPTH      (76800)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .addr_axiov (addr_axiov),
    .addr       (addr),
    .pixel_axiov(pixel_axiov),
    .pixel      (pixel),
    .audio_axiov(audio_axiov),
    .audio      (audio),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output log, sampled on the falling edge
  logic [7:0]  pix_log [0:2047];
  logic [7:0]  aud_log [0:255];
  int          pix_n = 0, aud_n = 0, addr_n = 0, err_n = 0, done_n = 0, viol_n = 0;
  logic [16:0] last_addr = 17'd0;
  int          addr_cyc = 0, err_cyc = 0, done_cyc = 0, last_strb = -100;

  always @(negedge clk) begin
    if (pixel_axiov) begin
      pix_log[pix_n[10:0]] <= pixel;
      pix_n <= pix_n + 1;
    end
    if (audio_axiov) begin
      aud_log[aud_n[7:0]] <= audio;
      aud_n <= aud_n + 1;
    end
    if (addr_axiov) begin
      addr_n    <= addr_n + 1;
      last_addr <= addr;
      addr_cyc  <= cyc;
    end
    if (pkt_err) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
    end
    if (pkt_done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if ((int'(addr_axiov) + int'(pixel_axiov) + int'(audio_axiov) > 1) ||
        (pkt_done && pkt_err) ||
        ((addr_axiov || pixel_axiov || audio_axiov) && (cyc - last_strb < 4)))
      viol_n <= viol_n + 1;
    if (addr_axiov || pixel_axiov || audio_axiov) last_strb <= cyc;
  end

  int n_cmp = 0, n_bad = 0;
  int start_cyc = 0, fall_cyc = 0;
  int b_pix, b_aud, b_addr, b_err, b_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_pix  = pix_n;
    b_aud  = aud_n;
    b_addr = addr_n;
    b_err  = err_n;
    b_done = done_n;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dibit(input logic [1:0] d);
    @(posedge clk);
    #1;
    axiiv = 1'b1;
    axiid = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    dibit(b[7:6]);
    dibit(b[5:4]);
    dibit(b[3:2]);
    dibit(b[1:0]);
  endtask

  task automatic end_pkt();
    @(posedge clk);
    #1;
    axiiv    = 1'b0;
    axiid    = 2'd0;
    fall_cyc = cyc;
  endtask

  task automatic send_hdr(input logic [23:0] a);
    start_cyc = cyc + 1;
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic send_packet(input logic [23:0] a, input int npix, input logic [7:0] pbase,
                             input int naud, input logic [7:0] abase, input int nfcs);
    send_hdr(a);
    for (int i = 0; i < npix; i++) send_byte(pbase + 8'(i));
    for (int i = 0; i < naud; i++) send_byte(abase + 8'(i));
    for (int i = 0; i < nfcs; i++) send_byte(8'h55);
    end_pkt();
  endtask

  task automatic check_pix(input string tag, input int base, input int n, input logic [7:0] pbase);
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), {24'd0, pix_log[11'(base + i)]}, {24'd0, pbase + 8'(i)});
  endtask

  task automatic check_aud(input string tag, input int base, input int n, input logic [7:0] abase);
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), {24'd0, aud_log[8'(base + i)]}, {24'd0, abase + 8'(i)});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr_axiov"},  {31'd0, addr_axiov},  32'd0);
    check({tag, "_addr"},        {15'd0, addr},        32'd0);
    check({tag, "_pixel_axiov"}, {31'd0, pixel_axiov}, 32'd0);
    check({tag, "_pixel"},       {24'd0, pixel},       32'd0);
    check({tag, "_audio_axiov"}, {31'd0, audio_axiov}, 32'd0);
    check({tag, "_audio"},       {24'd0, audio},       32'd0);
    check({tag, "_pkt_done"},    {31'd0, pkt_done},    32'd0);
    check({tag, "_pkt_err"},     {31'd0, pkt_err},     32'd0);
  endtask

  int r_pix, r_aud, r_addr, r_err, r_done;

  initial begin
    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = 2'd0;
    settle(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    settle(2);

    // Test 1: in-range address 320, full packet with FCS
    snap();
    send_packet(24'h000140, 320, 8'h00, 16, 8'hA0, 4);
    settle(3);
    check("t1_addr_cnt", addr_n - b_addr, 1);
    check("t1_addr_val", {15'd0, last_addr}, 320);
    check("t1_addr_cyc", addr_cyc, start_cyc + 12);
    check("t1_pix_cnt",  pix_n - b_pix, 320);
    check_pix("t1_pix", b_pix, 320, 8'h00);
    check("t1_aud_cnt",  aud_n - b_aud, 16);
    check_aud("t1_aud", b_aud, 16, 8'hA0);
    check("t1_done",     done_n - b_done, 1);
    check("t1_done_cyc", done_cyc, fall_cyc + 1);
    check("t1_err",      err_n - b_err, 0);
    check("t1_pix_hold", {24'd0, pixel}, 32'h3F);
    check("t1_aud_hold", {24'd0, audio}, 32'hAF);

    // Test 2: address 76672 beyond the last legal row start
    snap();
    send_packet(24'h012B80, 320, 8'h00, 16, 8'hA0, 4);
    settle(3);
    check("t2_addr_cnt", addr_n - b_addr, 0);
    check("t2_addr_reg", {15'd0, addr}, 32'h12B80);
    check("t2_pix_cnt",  pix_n - b_pix, 0);
    check("t2_err",      err_n - b_err, 1);
    check("t2_err_cyc",  err_cyc, start_cyc + 12);
    check("t2_aud_cnt",  aud_n - b_aud, 16);
    check_aud("t2_aud", b_aud, 16, 8'hA0);
    check("t2_done",     done_n - b_done, 1);

    // Test 3: upper header bits set are ignored
    snap();
    send_packet(24'hFE0000, 320, 8'h07, 16, 8'hA0, 4);
    settle(3);
    check("t3_addr_cnt", addr_n - b_addr, 1);
    check("t3_addr_val", {15'd0, last_addr}, 0);
    check("t3_pix_cnt",  pix_n - b_pix, 320);
    check_pix("t3_pix", b_pix, 320, 8'h07);
    check("t3_aud_cnt",  aud_n - b_aud, 16);
    check("t3_done",     done_n - b_done, 1);
    check("t3_err",      err_n - b_err, 0);

    // Test 4: packet cut after 100 pixels plus a half byte
    snap();
    send_hdr(24'h000000);
    for (int i = 0; i < 100; i++) send_byte(8'h11 + 8'(i));
    dibit(2'b10);
    dibit(2'b01);
    end_pkt();
    settle(3);
    check("t4_addr_cnt", addr_n - b_addr, 1);
    check("t4_pix_cnt",  pix_n - b_pix, 100);
    check_pix("t4_pix", b_pix, 100, 8'h11);
    check("t4_aud_cnt",  aud_n - b_aud, 0);
    check("t4_err",      err_n - b_err, 1);
    check("t4_err_cyc",  err_cyc, fall_cyc + 1);
    check("t4_done",     done_n - b_done, 0);

    // Test 5: back-to-back packets, one idle cycle apart; second ends on its last audio byte
    snap();
    send_packet(24'h000280, 320, 8'h30, 16, 8'hB0, 4);
    send_packet(24'h012AC0, 320, 8'h90, 16, 8'hC0, 0);
    settle(3);
    check("t5_addr_cnt", addr_n - b_addr, 2);
    check("t5_addr_val", {15'd0, last_addr}, 32'h12AC0);
    check("t5_pix_cnt",  pix_n - b_pix, 640);
    check_pix("t5a_pix", b_pix, 320, 8'h30);
    check_pix("t5b_pix", b_pix + 320, 320, 8'h90);
    check("t5_aud_cnt",  aud_n - b_aud, 32);
    check_aud("t5a_aud", b_aud, 16, 8'hB0);
    check_aud("t5b_aud", b_aud + 16, 16, 8'hC0);
    check("t5_done",     done_n - b_done, 2);
    check("t5_done_cyc", done_cyc, fall_cyc + 1);
    check("t5_err",      err_n - b_err, 0);

    // Test 6: reset in the middle of the pixel field, then a fresh packet
    send_hdr(24'h000100);
    for (int i = 0; i < 50; i++) send_byte(8'h40 + 8'(i));
    @(posedge clk);
    #1;
    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = 2'd0;
    r_pix = pix_n; r_aud = aud_n; r_addr = addr_n; r_err = err_n; r_done = done_n;
    #1;
    check_idle_outputs("t6_rst");
    settle(3);
    check_idle_outputs("t6_rst_hold");
    rst = 1'b0;
    settle(2);
    check("t6_rst_pix",  pix_n - r_pix, 0);
    check("t6_rst_addr", addr_n - r_addr, 0);
    check("t6_rst_aud",  aud_n - r_aud, 0);
    check("t6_rst_err",  err_n - r_err, 0);
    check("t6_rst_done", done_n - r_done, 0);
    snap();
    send_packet(24'h000200, 320, 8'h60, 16, 8'hD0, 4);
    settle(3);
    check("t6_addr_cnt", addr_n - b_addr, 1);
    check("t6_addr_val", {15'd0, last_addr}, 32'h200);
    check("t6_pix_cnt",  pix_n - b_pix, 320);
    check_pix("t6_pix", b_pix, 320, 8'h60);
    check("t6_aud_cnt",  aud_n - b_aud, 16);
    check_aud("t6_aud", b_aud, 16, 8'hD0);
    check("t6_done",     done_n - b_done, 1);
    check("t6_err",      err_n - b_err, 0);

    // Strobe exclusivity and spacing over the whole run
    check("strobe_rules", viol_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
